// File: rtl/matrix_multiplier_seq.sv
`default_nettype none
// =============================================================================
// Module  : matrix_multiplier_seq
// Purpose : N x N matrix product C = A x B on one time-shared MAC, with a
//           per-element result stream. Define MATMUL_SIGNED_EN for signed data.
// Rev     : 1.0 - initial release
// =============================================================================
module matrix_multiplier_seq #(
  parameter int N     = 2,
  parameter int W     = 3,
  parameter int ACC_W = (N > 1) ? 2*W + $clog2(N) : 2*W,
  parameter int CNT_W = $clog2(N*N+1)
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [N*N*W-1:0]                          matrix_a,
  input  logic [N*N*W-1:0]                          matrix_b,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      out_valid,
  output logic [((N > 1) ? $clog2(N*N) : 1)-1:0]    out_index,
  output logic [ACC_W-1:0]                          out_data,
  output logic [N*N*ACC_W-1:0]                      matrix_result,
  output logic [CNT_W-1:0]                          matrix_count
);

  localparam int C_NN    = N*N;
  localparam int C_IDX_W = (N > 1) ? $clog2(N*N) : 1;
  localparam int C_LP_W  = (N > 1) ? $clog2(N) : 1;
  localparam logic [C_LP_W-1:0] C_LAST = C_LP_W'(N-1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t               r_state;
  logic [C_NN*W-1:0]    r_a;
  logic [C_NN*W-1:0]    r_b;
  logic [C_LP_W-1:0]    r_i;
  logic [C_LP_W-1:0]    r_j;
  logic [C_LP_W-1:0]    r_k;
  logic [ACC_W-1:0]     r_acc;
  logic [ACC_W-1:0]     r_c [C_NN];
  logic                 r_busy;
  logic                 r_done;
  logic                 r_valid;
  logic [C_IDX_W-1:0]   r_index;
  logic [ACC_W-1:0]     r_data;
  logic [CNT_W-1:0]     r_count;

  logic [W-1:0]         w_a_arr [C_NN];
  logic [W-1:0]         w_b_arr [C_NN];
  logic [C_IDX_W-1:0]   w_a_idx;
  logic [C_IDX_W-1:0]   w_b_idx;
  logic [C_IDX_W-1:0]   w_c_idx;
  logic [ACC_W-1:0]     w_prod;
  logic [ACC_W-1:0]     w_sum;

  for (genvar e = 0; e < C_NN; e++) begin : g_elem
    assign w_a_arr[e] = r_a[e*W +: W];
    assign w_b_arr[e] = r_b[e*W +: W];
    assign matrix_result[e*ACC_W +: ACC_W] = r_c[e];
  end

  assign w_a_idx = C_IDX_W'(r_i) * C_IDX_W'(N) + C_IDX_W'(r_k);
  assign w_b_idx = C_IDX_W'(r_k) * C_IDX_W'(N) + C_IDX_W'(r_j);
  assign w_c_idx = C_IDX_W'(r_i) * C_IDX_W'(N) + C_IDX_W'(r_j);

  // Operands are widened to ACC_W before multiplying so the product is exact.
`ifdef MATMUL_SIGNED_EN
  logic signed [ACC_W-1:0] w_a_ext;
  logic signed [ACC_W-1:0] w_b_ext;
  assign w_a_ext = ACC_W'($signed(w_a_arr[w_a_idx]));
  assign w_b_ext = ACC_W'($signed(w_b_arr[w_b_idx]));
  assign w_prod  = w_a_ext * w_b_ext;
`else
  logic [ACC_W-1:0] w_a_ext;
  logic [ACC_W-1:0] w_b_ext;
  assign w_a_ext = ACC_W'(w_a_arr[w_a_idx]);
  assign w_b_ext = ACC_W'(w_b_arr[w_b_idx]);
  assign w_prod  = w_a_ext * w_b_ext;
`endif

  assign w_sum = r_acc + w_prod;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_index <= '0;
      r_data  <= '0;
      r_count <= '0;
      for (int e = 0; e < C_NN; e++) r_c[e] <= '0;
    end else begin
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= matrix_a;
            r_b     <= matrix_b;
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_k == C_LAST) begin
            r_c[w_c_idx] <= w_sum;
            r_valid      <= 1'b1;
            r_index      <= w_c_idx;
            r_data       <= w_sum;
            r_count      <= r_count + CNT_W'(1);
            r_acc        <= '0;
            r_k          <= '0;
            if (r_j == C_LAST) begin
              r_j <= '0;
              if (r_i == C_LAST) begin
                r_i     <= '0;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_i <= r_i + C_LP_W'(1);
              end
            end else begin
              r_j <= r_j + C_LP_W'(1);
            end
          end else begin
            r_acc <= w_sum;
            r_k   <= r_k + C_LP_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign out_valid    = r_valid;
  assign out_index    = r_index;
  assign out_data     = r_data;
  assign matrix_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_matrix_multiplier_seq.sv
`default_nettype none
// =============================================================================
// Module  : tb_matrix_multiplier_seq
// Purpose : Self-checking bench for matrix_multiplier_seq against a plain
//           arithmetic matrix-product model (honours MATMUL_SIGNED_EN).
// Rev     : 1.0 - initial release
// =============================================================================
module tb_matrix_multiplier_seq;

  localparam int N     = 2;
  localparam int W     = 3;
  localparam int ACC_W = (N > 1) ? 2*W + $clog2(N) : 2*W;
  localparam int CNT_W = $clog2(N*N+1);
  localparam int IDX_W = (N > 1) ? $clog2(N*N) : 1;
  localparam int NN    = N*N;
  localparam int AW    = NN*W;
  localparam int LAT   = N*N*N;

  logic                clock = 1'b0;
  logic                reset;
  logic                start;
  logic [AW-1:0]       matrix_a;
  logic [AW-1:0]       matrix_b;
  logic                busy;
  logic                done;
  logic                out_valid;
  logic [IDX_W-1:0]    out_index;
  logic [ACC_W-1:0]    out_data;
  logic [NN*ACC_W-1:0] matrix_result;
  logic [CNT_W-1:0]    matrix_count;

  int checks = 0;
  int errors = 0;

  int ev_idx[$];
  int ev_data[$];
  int ev_cyc[$];
  int done_cyc;
  int done_pulses;
  int busy_cycles;

  matrix_multiplier_seq #(.N(N), .W(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .matrix_a     (matrix_a),
    .matrix_b     (matrix_b),
    .busy         (busy),
    .done         (done),
    .out_valid    (out_valid),
    .out_index    (out_index),
    .out_data     (out_data),
    .matrix_result(matrix_result),
    .matrix_count (matrix_count)
  );

  always #5 clock = ~clock;

  function automatic int elem_val(input logic [AW-1:0] m, input int e);
    int v;
    v = int'(m[e*W +: W]);
`ifdef MATMUL_SIGNED_EN
    if (v >= (1 << (W-1))) v = v - (1 << W);
`endif
    return v;
  endfunction

  // Textbook C[r][c] = sum_k A[r][k]*B[k][c], truncated to ACC_W bits.
  function automatic logic [NN*ACC_W-1:0] model(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [NN*ACC_W-1:0] c;
    longint s;
    c = '0;
    for (int r = 0; r < N; r++)
      for (int col = 0; col < N; col++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += longint'(elem_val(a, r*N+k) * elem_val(b, k*N+col));
        c[(r*N+col)*ACC_W +: ACC_W] = ACC_W'(s);
      end
    return c;
  endfunction

  function automatic int res_elem(input logic [NN*ACC_W-1:0] v, input int e);
    return int'(v[e*ACC_W +: ACC_W]);
  endfunction

  function automatic logic [AW-1:0] pack(input int v [NN]);
    logic [AW-1:0] m;
    m = '0;
    for (int e = 0; e < NN; e++) m[e*W +: W] = W'(v[e]);
    return m;
  endfunction

  // Starts one run and records the stream; matrix_a is scrambled right after start.
  task automatic do_run(input logic [AW-1:0] a, input logic [AW-1:0] b);
    ev_idx.delete(); ev_data.delete(); ev_cyc.delete();
    done_cyc = -1; done_pulses = 0; busy_cycles = 0;
    @(negedge clock);
    matrix_a = a; matrix_b = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    matrix_a = AW'($urandom);
    for (int cyc = 0; cyc <= LAT + 3; cyc++) begin
      if (cyc > 0) begin @(posedge clock); #1; end
      if (busy) busy_cycles++;
      if (out_valid) begin
        ev_idx.push_back(int'(out_index));
        ev_data.push_back(int'(out_data));
        ev_cyc.push_back(cyc);
      end
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; matrix_a = '0; matrix_b = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy, done, out_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, out_valid});
    end
    checks++;
    if (matrix_count !== '0 || matrix_result !== '0) begin
      errors++; $display("FAIL reset_regs: got count %0d result %h expected 0 0", matrix_count, matrix_result);
    end
    checks++;
    if (out_index !== '0 || out_data !== '0) begin
      errors++; $display("FAIL reset_stream: got idx %0d data %0d expected 0 0", out_index, out_data);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [AW-1:0] a, b;
    int va [NN];
    int vb [NN];
    int exp_data [NN];
    va = '{1, 2, 3, 4};
    vb = '{5, 6, 7, 0};
    a = pack(va); b = pack(vb);
`ifdef MATMUL_SIGNED_EN
    for (int e = 0; e < NN; e++) exp_data[e] = res_elem(model(a, b), e);
`else
    exp_data = '{19, 6, 43, 18};
`endif
    do_run(a, b);
    checks++;
    if (ev_idx.size() != NN) begin
      errors++; $display("FAIL basic_count: got %0d elements expected %0d", ev_idx.size(), NN);
    end else begin
      for (int e = 0; e < NN; e++) begin
        checks++;
        if (ev_idx[e] != e || ev_data[e] != exp_data[e] || ev_cyc[e] != N*(e+1)) begin
          errors++;
          $display("FAIL basic_elem[%0d]: got idx %0d data %0d cyc %0d expected idx %0d data %0d cyc %0d",
                   e, ev_idx[e], ev_data[e], ev_cyc[e], e, exp_data[e], N*(e+1));
        end
      end
    end
    checks++;
    if (done_cyc != LAT || done_pulses != 1) begin
      errors++; $display("FAIL basic_done: got cyc %0d pulses %0d expected cyc %0d pulses 1", done_cyc, done_pulses, LAT);
    end
    checks++;
    if (int'(matrix_count) != NN) begin
      errors++; $display("FAIL basic_matrix_count: got %0d expected %0d", matrix_count, NN);
    end
    for (int e = 0; e < NN; e++) begin
      checks++;
      if (res_elem(matrix_result, e) != exp_data[e]) begin
        errors++; $display("FAIL basic_result[%0d]: got %0d expected %0d", e, res_elem(matrix_result, e), exp_data[e]);
      end
    end
  endtask

  task automatic test_max();
    logic [AW-1:0] a;
    int exp_v;
    a = '1;
`ifdef MATMUL_SIGNED_EN
    exp_v = res_elem(model(a, a), 0);
`else
    exp_v = 98;
`endif
    do_run(a, a);
    for (int e = 0; e < NN; e++) begin
      checks++;
      if (res_elem(matrix_result, e) != exp_v) begin
        errors++; $display("FAIL max_result[%0d]: got %0d expected %0d", e, res_elem(matrix_result, e), exp_v);
      end
    end
    checks++;
    if (busy_cycles != LAT) begin
      errors++; $display("FAIL max_busy_cycles: got %0d expected %0d", busy_cycles, LAT);
    end
  endtask

  task automatic test_signed();
    logic [AW-1:0] a, b;
    int vb [NN];
    int exp_v;
    for (int e = 0; e < NN; e++) vb[e] = 3;
    a = '1; b = pack(vb);
`ifdef MATMUL_SIGNED_EN
    exp_v = 7'b1111010;
`else
    exp_v = 42;
`endif
    do_run(a, b);
    for (int e = 0; e < NN; e++) begin
      checks++;
      if (res_elem(matrix_result, e) != exp_v) begin
        errors++; $display("FAIL signed_result[%0d]: got %0d expected %0d", e, res_elem(matrix_result, e), exp_v);
      end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a, b;
    logic [NN*ACC_W-1:0] exp_c;
    for (int it = 0; it < 8; it++) begin
      a = AW'($urandom); b = AW'($urandom);
      exp_c = model(a, b);
      do_run(a, b);
      checks++;
      if (ev_idx.size() != NN) begin
        errors++; $display("FAIL rand%0d_count: got %0d elements expected %0d", it, ev_idx.size(), NN);
      end else begin
        for (int e = 0; e < NN; e++) begin
          checks++;
          if (ev_idx[e] != e || ev_data[e] != res_elem(exp_c, e) || ev_cyc[e] != N*(e+1)) begin
            errors++;
            $display("FAIL rand%0d_elem[%0d]: got idx %0d data %0d cyc %0d expected idx %0d data %0d cyc %0d",
                     it, e, ev_idx[e], ev_data[e], ev_cyc[e], e, res_elem(exp_c, e), N*(e+1));
          end
        end
      end
      checks++;
      if (matrix_result !== exp_c || int'(matrix_count) != NN) begin
        errors++; $display("FAIL rand%0d_result: got %h count %0d expected %h count %0d", it, matrix_result, matrix_count, exp_c, NN);
      end
      checks++;
      if (done_cyc != LAT || done_pulses != 1 || busy_cycles != LAT) begin
        errors++; $display("FAIL rand%0d_timing: got done %0d pulses %0d busy %0d expected %0d 1 %0d",
                           it, done_cyc, done_pulses, busy_cycles, LAT, LAT);
      end
      checks++;
      if (int'(out_index) != NN-1 || int'(out_data) != res_elem(exp_c, NN-1)) begin
        errors++; $display("FAIL rand%0d_hold: got idx %0d data %0d expected %0d %0d", it, out_index, out_data, NN-1, res_elem(exp_c, NN-1));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a1, a2, b;
    logic [NN*ACC_W-1:0] prev;
    int idle_cycles;
    a1 = AW'($urandom); a2 = AW'($urandom); b = AW'($urandom);
    prev = matrix_result;
    idle_cycles = 0;
    @(negedge clock);
    matrix_a = a1; matrix_b = b; start = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (matrix_result !== prev) begin
      errors++; $display("FAIL b2b_result_hold: got %h expected %h", matrix_result, prev);
    end
    for (int cyc = 1; cyc <= 2*LAT + 1; cyc++) begin
      @(posedge clock); #1;
      if (cyc == 3) matrix_a = a2;
      if (cyc <= 2*LAT && !busy) idle_cycles++;
      if (cyc == LAT) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || matrix_result !== model(a1, b)) begin
          errors++; $display("FAIL b2b_first: got done %b busy %b result %h expected 1 0 %h", done, busy, matrix_result, model(a1, b));
        end
      end
      if (cyc == LAT + 1) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++; $display("FAIL b2b_restart: got busy %b done %b expected 1 0", busy, done);
        end
      end
      if (cyc == 2*LAT + 1) begin
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || matrix_result !== model(a2, b)) begin
          errors++; $display("FAIL b2b_second: got done %b result %h expected 1 %h", done, matrix_result, model(a2, b));
        end
      end
    end
    checks++;
    if (idle_cycles != 1) begin
      errors++; $display("FAIL b2b_idle_gap: got %0d expected 1", idle_cycles);
    end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a, b;
    int early_done;
    a = AW'($urandom); b = AW'($urandom);
    early_done = 0;
    @(negedge clock);
    matrix_a = a; matrix_b = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, out_valid} !== 3'b000 || matrix_count !== '0 || matrix_result !== '0) begin
      errors++; $display("FAIL midreset_clear: got flags %b count %0d result %h expected 000 0 0",
                         {busy, done, out_valid}, matrix_count, matrix_result);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      if (done) early_done++;
    end
    checks++;
    if (early_done != 0) begin
      errors++; $display("FAIL midreset_no_done: got %0d pulses expected 0", early_done);
    end
    @(negedge clock);
    reset = 1'b0;
    a = AW'($urandom); b = AW'($urandom);
    do_run(a, b);
    checks++;
    if (matrix_result !== model(a, b) || done_cyc != LAT || int'(matrix_count) != NN) begin
      errors++; $display("FAIL midreset_rerun: got %h done %0d count %0d expected %h %0d %0d",
                         matrix_result, done_cyc, matrix_count, model(a, b), LAT, NN);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_signed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
